// File: rtl/image_pkg.sv
// Shared types and constants for the BMP frame writer: FSM encoding, header layout
// and default frame geometry.
package image_pkg;

    typedef enum logic [1:0] {StIdle, StCapture, StSend, StDone} state_e;

    localparam int unsigned BMP_HDR_LEN    = 54;
    localparam int unsigned DEFAULT_WIDTH  = 768;
    localparam int unsigned DEFAULT_HEIGHT = 512;

    // Byte offsets of BITMAPFILEHEADER/BITMAPINFOHEADER fields
    localparam logic [5:0] HdrOffSig      = 6'd0;
    localparam logic [5:0] HdrOffFileSize = 6'd2;
    localparam logic [5:0] HdrOffReserved = 6'd6;
    localparam logic [5:0] HdrOffDataOff  = 6'd10;
    localparam logic [5:0] HdrOffInfoSize = 6'd14;
    localparam logic [5:0] HdrOffWidth    = 6'd18;
    localparam logic [5:0] HdrOffHeight   = 6'd22;
    localparam logic [5:0] HdrOffPlanes   = 6'd26;
    localparam logic [5:0] HdrOffBpp      = 6'd28;
    localparam logic [5:0] HdrOffCompr    = 6'd30;
    localparam logic [5:0] HdrOffImgSize  = 6'd34;
    localparam logic [5:0] HdrOffPad      = 6'd38;

    // Little-endian byte k of a 32-bit field
    function automatic logic [7:0] le_byte(logic [31:0] v, logic [5:0] k);
        return 8'(v >> {k, 3'b000});
    endfunction

endpackage

// File: rtl/image_write_if.sv
// Video input stream plus BMP byte output port of the frame writer.
// master = stream source / byte consumer, slave = image_write.
interface image_write_if;

    logic       VSYNC;
    logic       HSYNC;
    logic [7:0] DATA_WRITE_R0;
    logic [7:0] DATA_WRITE_G0;
    logic [7:0] DATA_WRITE_B0;
    logic [7:0] DATA_WRITE_R1;
    logic [7:0] DATA_WRITE_G1;
    logic [7:0] DATA_WRITE_B1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       write_done;
    logic       overrun;

    modport master (
        output VSYNC, HSYNC,
        output DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        output DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
        output out_ready,
        input  out_data, out_valid, write_done, overrun
    );

    modport slave (
        input  VSYNC, HSYNC,
        input  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        input  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
        input  out_ready,
        output out_data, out_valid, write_done, overrun
    );

endinterface

// File: rtl/bmp_header_rom.sv
// Combinational lookup of the 54-byte 24-bit BMP header for a fixed frame size.
module bmp_header_rom
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT = DEFAULT_HEIGHT
) (
    input  logic [5:0] idx,
    output logic [7:0] hdr_byte
);

    localparam logic [31:0] ImgSize  = 32'(WIDTH * HEIGHT * 3);
    localparam logic [31:0] FileSize = ImgSize + 32'(BMP_HDR_LEN);

    logic [31:0] f_val;
    logic [5:0]  f_off;

    // Pick the field covering idx; reserved/compression/padding bytes fall to zero
    always_comb begin
        f_val = '0;
        f_off = '0;
        if (idx < HdrOffFileSize) begin
            f_val = 32'h0000_4D42;
            f_off = HdrOffSig;
        end else if (idx < HdrOffReserved) begin
            f_val = FileSize;
            f_off = HdrOffFileSize;
        end else if (idx < HdrOffDataOff) begin
            f_val = '0;
        end else if (idx < HdrOffInfoSize) begin
            f_val = 32'(BMP_HDR_LEN);
            f_off = HdrOffDataOff;
        end else if (idx < HdrOffWidth) begin
            f_val = 32'd40;
            f_off = HdrOffInfoSize;
        end else if (idx < HdrOffHeight) begin
            f_val = 32'(WIDTH);
            f_off = HdrOffWidth;
        end else if (idx < HdrOffPlanes) begin
            f_val = 32'(HEIGHT);
            f_off = HdrOffHeight;
        end else if (idx < HdrOffBpp) begin
            f_val = 32'd1;
            f_off = HdrOffPlanes;
        end else if (idx < HdrOffCompr) begin
            f_val = 32'd24;
            f_off = HdrOffBpp;
        end else if (idx < HdrOffImgSize) begin
            f_val = '0;
        end else if (idx < HdrOffPad) begin
            f_val = ImgSize;
            f_off = HdrOffImgSize;
        end
        hdr_byte = le_byte(f_val, idx - f_off);
    end

endmodule

// File: rtl/image_write.sv
// Captures one 2-pixel-per-clock RGB888 frame, stores it bottom-up and streams it
// out as a complete 24-bit BMP file on a byte valid/ready port.
module image_write
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT = DEFAULT_HEIGHT
) (
    input  logic        HCLK,
    input  logic        HRESET,
    image_write_if.slave bus
);

    localparam int unsigned ImgBytes  = WIDTH * HEIGHT * 3;
    localparam int unsigned FileBytes = ImgBytes + BMP_HDR_LEN;
    localparam int unsigned IdxW      = $clog2(FileBytes);
    localparam int unsigned AddrW     = $clog2(ImgBytes);
    localparam int unsigned RowW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned ColW      = $clog2(WIDTH) + 1;

    localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 2);
    localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(FileBytes - 1);
    localparam logic [IdxW-1:0] IdxHdr  = IdxW'(BMP_HDR_LEN);

    state_e          state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic [ColW-1:0] col_q, col_d;
    logic [IdxW-1:0] byte_idx_q, byte_idx_d;
    logic            out_valid_q, out_valid_d;
    logic            write_done_q, write_done_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      out_data_q;

    logic [7:0]      mem [0:ImgBytes-1];
    logic [AddrW-1:0] wr_base;
    logic [AddrW-1:0] rd_addr;
    logic [7:0]      hdr_byte;
    logic            capture;
    logic            last_beat;
    logic            fire;

    assign fire      = out_valid_q && bus.out_ready;
    assign last_beat = (row_q == RowLast) && (col_q == ColLast);
    // Row order flipped here so the send side reads the buffer linearly
    assign wr_base   = AddrW'(RowLast - row_q) * AddrW'(WIDTH * 3) + AddrW'(col_q) * AddrW'(3);
    assign rd_addr   = AddrW'(byte_idx_d - IdxHdr);

    bmp_header_rom #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_hdr_rom (
        .idx      (byte_idx_d[5:0]),
        .hdr_byte (hdr_byte)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        byte_idx_d   = byte_idx_q;
        out_valid_d  = 1'b0;
        write_done_d = write_done_q;
        overrun_d    = overrun_q;
        capture      = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                capture = bus.HSYNC;
            end
            StCapture: begin
                if (bus.VSYNC) begin
                    state_d = StIdle;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    capture = bus.HSYNC;
                end
            end
            StSend: begin
                if (bus.HSYNC) begin
                    overrun_d = 1'b1;
                end
                if (fire && (byte_idx_q == IdxLast)) begin
                    state_d      = StDone;
                    write_done_d = 1'b1;
                    byte_idx_d   = '0;
                end else begin
                    out_valid_d = 1'b1;
                    if (fire) begin
                        byte_idx_d = byte_idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            write_done_d = 1'b0;
            if (last_beat) begin
                state_d    = StSend;
                row_d      = '0;
                col_d      = '0;
                byte_idx_d = '0;
            end else begin
                state_d = StCapture;
                if (col_q == ColLast) begin
                    col_d = '0;
                    row_d = row_q + RowW'(1);
                end else begin
                    col_d = col_q + ColW'(2);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            byte_idx_q   <= '0;
            out_valid_q  <= 1'b0;
            write_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            byte_idx_q   <= byte_idx_d;
            out_valid_q  <= out_valid_d;
            write_done_q <= write_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Prefetch the byte that will be presented next cycle; reloads the same byte while stalled
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            out_data_q <= '0;
        end else if (out_valid_d) begin
            if (byte_idx_d < IdxHdr) begin
                out_data_q <= hdr_byte;
            end else begin
                out_data_q <= mem[rd_addr];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (capture) begin
            mem[wr_base]              <= bus.DATA_WRITE_B0;
            mem[wr_base + AddrW'(1)]  <= bus.DATA_WRITE_G0;
            mem[wr_base + AddrW'(2)]  <= bus.DATA_WRITE_R0;
            mem[wr_base + AddrW'(3)]  <= bus.DATA_WRITE_B1;
            mem[wr_base + AddrW'(4)]  <= bus.DATA_WRITE_G1;
            mem[wr_base + AddrW'(5)]  <= bus.DATA_WRITE_R1;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.write_done = write_done_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_image_write.sv
// Directed bench for image_write at 4x2: full-file compare, stalls, VSYNC discard,
// overrun and asynchronous reset during the send phase.
module tb_image_write;

    localparam int unsigned W       = 4;
    localparam int unsigned H       = 2;
    localparam int unsigned FileLen = 54 + W * H * 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] exp_bytes [FileLen];
    logic [7:0] got [$];

    always #5 clk = ~clk;

    image_write_if bus ();

    image_write #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Beat k of a 4x2 frame: pixel (r,c) = (R,G,B) = (64r+c, 64r+c+16, 64r+c+32), xored with xr
    task automatic drive_beat(input int k, input logic [7:0] xr);
        int r;
        int c;
        logic [7:0] v;
        r = k / 2;
        c = 2 * (k % 2);
        v = 8'(r * 64 + c);
        bus.HSYNC         = 1'b1;
        bus.DATA_WRITE_R0 = v ^ xr;
        bus.DATA_WRITE_G0 = (v + 8'd16) ^ xr;
        bus.DATA_WRITE_B0 = (v + 8'd32) ^ xr;
        bus.DATA_WRITE_R1 = (v + 8'd1) ^ xr;
        bus.DATA_WRITE_G1 = (v + 8'd17) ^ xr;
        bus.DATA_WRITE_B1 = (v + 8'd33) ^ xr;
        step();
        bus.HSYNC = 1'b0;
    endtask

    task automatic full_frame();
        for (int k = 0; k < 4; k++) drive_beat(k, 8'h00);
    endtask

    // Collect the BMP file; inject_at >= 0 drives a stray HSYNC (and later VSYNC) during SEND
    task automatic recv(input bit rand_ready, input int inject_at);
        int         cyc;
        bit         stalled;
        logic [7:0] held;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        got.delete();
        while (got.size() < FileLen && cyc < 2000) begin
            if (stalled) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_hold", 32'(bus.out_data), 32'(held));
            end
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.HSYNC     = (inject_at >= 0) && (cyc == inject_at);
            bus.VSYNC     = (inject_at >= 0) && (cyc == inject_at + 5);
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                stalled = 1'b0;
            end else begin
                stalled = bus.out_valid;
                held    = bus.out_data;
            end
            step();
            cyc++;
        end
        bus.HSYNC     = 1'b0;
        bus.VSYNC     = 1'b0;
        bus.out_ready = 1'b1;
        check("recv_len", 32'(got.size()), 32'(FileLen));
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < got.size() && i < FileLen; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_bytes[i]));
        end
        check({tag, "_done"}, 32'(bus.write_done), 32'd1);
        check({tag, "_valid_off"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        // Expected file: hand-computed header, then image rows bottom-up as B,G,R
        exp_bytes = '{default: 8'h00};
        exp_bytes[0]  = 8'h42;
        exp_bytes[1]  = 8'h4D;
        exp_bytes[2]  = 8'h4E;
        exp_bytes[10] = 8'h36;
        exp_bytes[14] = 8'h28;
        exp_bytes[18] = 8'h04;
        exp_bytes[22] = 8'h02;
        exp_bytes[26] = 8'h01;
        exp_bytes[28] = 8'h18;
        exp_bytes[34] = 8'h18;
        for (int br = 0; br < 2; br++) begin
            for (int c = 0; c < 4; c++) begin
                int base;
                int v;
                base = 54 + br * 12 + 3 * c;
                v    = (1 - br) * 64 + c;
                exp_bytes[base]     = 8'(v + 32);
                exp_bytes[base + 1] = 8'(v + 16);
                exp_bytes[base + 2] = 8'(v);
            end
        end

        bus.VSYNC = 1'b0;
        bus.HSYNC = 1'b0;
        bus.DATA_WRITE_R0 = '0;
        bus.DATA_WRITE_G0 = '0;
        bus.DATA_WRITE_B0 = '0;
        bus.DATA_WRITE_R1 = '0;
        bus.DATA_WRITE_G1 = '0;
        bus.DATA_WRITE_B1 = '0;
        bus.out_ready = 1'b1;

        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_done", 32'(bus.write_done), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Plain frame with a gap cycle, consumer always ready
        drive_beat(0, 8'h00);
        step();
        drive_beat(1, 8'h00);
        drive_beat(2, 8'h00);
        drive_beat(3, 8'h00);
        check("s2_first_hdr_wait", 32'(bus.out_valid), 32'd0);
        recv(1'b0, -1);
        check_frame("s2");
        check("s2_overrun", 32'(bus.overrun), 32'd0);
        repeat (3) step();
        check("s2_done_hold", 32'(bus.write_done), 32'd1);

        // New frame from DONE; write_done drops on the first beat, random backpressure
        drive_beat(0, 8'h00);
        check("s3_done_clear", 32'(bus.write_done), 32'd0);
        for (int k = 1; k < 4; k++) drive_beat(k, 8'h00);
        recv(1'b1, -1);
        check_frame("s3");

        // Partial frame of corrupt data, then VSYNC, then a clean frame
        drive_beat(0, 8'hFF);
        drive_beat(1, 8'hFF);
        bus.VSYNC = 1'b1;
        step();
        bus.VSYNC = 1'b0;
        step();
        check("s4_idle_valid", 32'(bus.out_valid), 32'd0);
        check("s4_idle_done", 32'(bus.write_done), 32'd0);
        full_frame();
        recv(1'b0, -1);
        check_frame("s4");

        // Stray HSYNC/VSYNC during SEND: overrun sticks, stream unaffected
        full_frame();
        check("s5_overrun_pre", 32'(bus.overrun), 32'd0);
        recv(1'b0, 20);
        check_frame("s5");
        check("s5_overrun", 32'(bus.overrun), 32'd1);
        repeat (4) step();
        check("s5_overrun_sticky", 32'(bus.overrun), 32'd1);

        // Asynchronous reset in the middle of SEND
        full_frame();
        repeat (10) step();
        check("s1_mid_send", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s1_rst_valid", 32'(bus.out_valid), 32'd0);
        check("s1_rst_done", 32'(bus.write_done), 32'd0);
        check("s1_rst_overrun", 32'(bus.overrun), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check("s1_idle_valid", 32'(bus.out_valid), 32'd0);
        full_frame();
        recv(1'b1, -1);
        check_frame("s1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
